// File: rtl/dct_transpose_pp_if.sv
// Stream bundle for the DCT transpose buffer: column-major input side, row-major output side.
// Optional feature macro: TP_MODE_SEL_EN adds the per-block mode select (1 = transpose, 0 = pass-through).
interface dct_transpose_pp_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
`ifdef TP_MODE_SEL_EN
  logic         mode;

  modport slave (
    input  in_valid, in_data, out_ready, mode,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready, mode,
    input  in_ready, out_valid, out_data, out_last
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
`endif
endinterface

// File: rtl/dct_transpose_pp.sv
// Ping-pong NxN transpose buffer between the column and row 1-D DCTs, valid/ready on both sides.
// Optional feature macro: TP_MODE_SEL_EN (per-block transpose/pass-through select via bus.mode).
module dct_transpose_pp #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dct_transpose_pp_if.slave    bus
);
  localparam int LG = $clog2(N);
  localparam int NN = N * N;
  localparam int AW = 2 * LG + 1;

  logic [W-1:0]  r_mem [2*NN];
  logic [LG-1:0] r_wr_row, r_wr_col;
  logic [LG-1:0] r_rd_row, r_rd_col;
  logic          r_wb, r_rb;
  logic [1:0]    r_full;
  logic          r_out_valid, r_out_last;
  logic [W-1:0]  r_out_data;

  logic          w_in_ready, w_in_fire, w_wr_last;
  logic          w_load, w_rd_last;
  logic [AW-1:0] w_wr_addr, w_rd_addr;
  logic [1:0]    w_full_nxt;

  assign w_in_ready = ~r_full[r_wb];
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_wr_last  = (&r_wr_row) & (&r_wr_col);
  assign w_load     = r_full[r_rb] & (~r_out_valid | bus.out_ready);
  assign w_rd_last  = (&r_rd_row) & (&r_rd_col);

  // Banks are stored row-major: {bank, row, col}; the write side walks rows fastest.
  assign w_wr_addr = {r_wb, r_wr_row, r_wr_col};

`ifdef TP_MODE_SEL_EN
  logic [1:0] r_mode;

  assign w_rd_addr = r_mode[r_rb] ? {r_rb, r_rd_row, r_rd_col}
                                  : {r_rb, r_rd_col, r_rd_row};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 2'b11;
    end else if (w_in_fire && r_wr_row == '0 && r_wr_col == '0) begin
      r_mode[r_wb] <= bus.mode;
    end
  end
`else
  assign w_rd_addr = {r_rb, r_rd_row, r_rd_col};
`endif

  // A completing write and a completing read always target different banks.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_full_nxt = r_full;
    if (w_in_fire && w_wr_last) w_full_nxt[r_wb] = 1'b1;
    if (w_load && w_rd_last)    w_full_nxt[r_rb] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_row    <= '0;
      r_wr_col    <= '0;
      r_rd_row    <= '0;
      r_rd_col    <= '0;
      r_wb        <= 1'b0;
      r_rb        <= 1'b0;
      r_full      <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge state.
      r_full <= w_full_nxt;
      if (w_in_fire) begin
        r_wr_row <= r_wr_row + LG'(1);
        if (&r_wr_row) r_wr_col <= r_wr_col + LG'(1);
        if (w_wr_last) r_wb <= ~r_wb;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[w_rd_addr];
        r_out_last  <= w_rd_last;
        r_rd_col    <= r_rd_col + LG'(1);
        if (&r_rd_col) r_rd_row <= r_rd_row + LG'(1);
        if (w_rd_last) r_rb <= ~r_rb;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // NOTE: storage has no reset; the full flags alone decide which contents are live.
  always_ff @(posedge clk) begin
    if (w_in_fire && !rst) r_mem[w_wr_addr] <= bus.in_data;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_dct_transpose_pp.sv
// Self-checking bench for dct_transpose_pp: directed scenarios plus random traffic against a block-level model.
module tb_dct_transpose_pp;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int NN = N * N;

  typedef struct {
    logic [W-1:0] d;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct_transpose_pp_if #(.W(W)) bus ();
  dct_transpose_pp #(.W(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  exp_t         exp_q[$];
  logic [W-1:0] blk[$];
  bit           blk_mode;
  logic [W-1:0] cap_q[$];
  bit           cap_en = 1'b0;
  longint       cyc = 0;
  int           n_acc = 0;
  int           rdy_sel = 1;      // 0: hold low, 1: hold high, 2: random
  bit           stream_mon = 1'b0;
  int           stall_cnt = 0;
  longint       first_out_cyc = -1;
  longint       pulse_q[$];
  bit           send_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_sel)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: whole blocks in, expected order out; a reset discards everything pending.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      blk.delete();
      exp_q.delete();
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_last", bus.out_last, e.last);
          if (cap_en) cap_q.push_back(bus.out_data);
          if (stream_mon) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (e.last) pulse_q.push_back(cyc);
          end
        end
      end
      if (stream_mon && bus.in_valid && bus.in_ready !== 1'b1) stall_cnt++;
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        n_acc++;
`ifdef TP_MODE_SEL_EN
        if (blk.size() == 0) blk_mode = bus.mode;
`else
        if (blk.size() == 0) blk_mode = 1'b1;
`endif
        blk.push_back(bus.in_data);
        if (blk.size() == NN) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              e.d    = blk_mode ? blk[c * N + r] : blk[r * N + c];
              e.last = (r == N - 1) && (c == N - 1);
              exp_q.push_back(e);
            end
          end
          blk.delete();
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit gaps);
    int t = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) begin
      chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_range(input int base, input int count, input bit rnd, input bit gaps);
    for (int i = 0; i < count; i++) send(rnd ? W'($urandom) : W'(base + i), gaps);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, 64'(exp_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef TP_MODE_SEL_EN
    bus.mode = 1'b1;
`endif

    // Reset with in_valid held high
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    repeat (80) @(posedge clk);
    #1;
    chk("rst_no_accept", bus.out_valid, 0);

    // Single block 0..63, latency and transposed order
    rdy_sel = 1;
    @(posedge clk); #1;
    for (int i = 0; i < NN; i++) send(W'(i), 1'b0);
    chk("lat_edge_k", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("lat_edge_k1", bus.out_valid, 1);
    chk("lat_first_data", bus.out_data, 0);
    wait_drain("drain_single");

    // Backpressure: both banks fill, output holds its first sample
    rdy_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    base      = n_acc;
    send_done = 1'b0;
    fork
      begin
        send_range(0, 3 * NN, 1'b0, 1'b0);
        send_done = 1'b1;
      end
    join_none
    t = 0;
    while (n_acc - base < 2 * NN && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("bp_accepts", 64'(n_acc - base), 2 * NN);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_out_data", bus.out_data, 0);
    chk("bp_out_last", bus.out_last, 0);
    rdy_sel = 1;
    t = 0;
    while (!send_done && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_send_done", send_done, 1);
    wait_drain("drain_bp");

    // Continuous stream of 4 blocks
    stall_cnt     = 0;
    first_out_cyc = -1;
    pulse_q.delete();
    stream_mon = 1'b1;
    send_range(0, 4 * NN, 1'b1, 1'b0);
    wait_drain("drain_stream");
    stream_mon = 1'b0;
    chk("stream_stalls", 64'(stall_cnt), 0);
    chk("stream_pulses", 64'(pulse_q.size()), 4);
    if (pulse_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("stream_pulse_gap", 64'(pulse_q[i] - pulse_q[i-1]), NN);
      chk("stream_no_bubble", 64'(pulse_q[3] - first_out_cyc), 4 * NN - 1);
    end

    // Reset in the middle of a block discards the partial block
    send_range(1000, 30, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cap_q.delete();
    cap_en = 1'b1;
    send_range(100, NN, 1'b0, 1'b0);
    wait_drain("drain_midrst");
    cap_en = 1'b0;
    chk("midrst_count", 64'(cap_q.size()), NN);
    if (cap_q.size() >= 2) begin
      chk("midrst_first", cap_q[0], 100);
      chk("midrst_second", cap_q[1], 108);
    end

    // Random traffic with input gaps and random backpressure
    rdy_sel = 2;
    send_range(0, 5 * NN, 1'b1, 1'b1);
    wait_drain("drain_random");
    rdy_sel = 1;

`ifdef TP_MODE_SEL_EN
    // Pass-through block followed by a transposed block
    cap_q.delete();
    cap_en   = 1'b1;
    bus.mode = 1'b0;
    send_range(0, NN, 1'b0, 1'b0);
    bus.mode = 1'b1;
    send_range(NN, NN, 1'b0, 1'b0);
    wait_drain("drain_mode");
    cap_en = 1'b0;
    if (cap_q.size() == 2 * NN) begin
      chk("mode_pass_1", cap_q[1], 1);
      chk("mode_tp_1", cap_q[NN + 1], NN + 8);
    end
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("final_idle", bus.out_valid, 0);
    chk("final_leftover", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dct_transpose_pp.md
# dct_transpose_pp

Parametrised ping-pong transpose buffer for the 2-D DCT datapath, placed between the 1-D column DCT and the 1-D row DCT. It accepts one NxN block of coefficients in column-major order and emits the same block in row-major order, which is the transpose. Two banks let one block fill while the previous block drains, giving one sample per cycle when the stream is continuous. Valid/ready handshakes on both sides provide backpressure in both directions.

## Interface
- W, 32, sample width in bits
- N, 8, block dimension; power of two, 2..32; block = N*N samples

- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  in_data is valid
- in_ready  out  1  buffer can accept a sample this cycle
- in_data  in  W  input sample, column-major order (row index advances fastest)
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  W  output sample, row-major order (column index advances fastest)
- out_last  out  1  marks the final sample (index N*N-1) of a block; qualified by out_valid
- mode  in  1  present only with TP_MODE_SEL_EN; 1 = transpose, 0 = pass-through

## Operation
- Storage: 2 banks of N*N x W. Per-bank full flags full[1:0]. Write-bank pointer wb and read-bank pointer rb, each 1 bit.
- Input accept happens when in_valid & in_ready. in_ready = !full[wb], as a combinational function of registered state.
- Write addressing: counters wr_row and wr_col, each log2(N) bits. An accepted sample is stored at [wr_row][wr_col]. wr_row then increments. When wr_row wraps to 0, wr_col increments.
- On the final sample of a block (wr_row = wr_col = N-1): set full[wb], toggle wb, and clear both counters to 0.
- Read addressing: counters rd_row and rd_col. The read side uses a single registered output stage.
  - The output stage loads when full[rb] is set and (!out_valid | out_ready).
  - The load sets out_data = bank[rb][rd_row][rd_col] and sets out_last when rd_row = rd_col = N-1.
  - After the load, rd_col increments. When rd_col wraps, rd_row increments.
- On loading the last sample of a block: clear full[rb], toggle rb, and clear the read counters.
- Output accept happens when out_valid & out_ready. If there is no load that cycle, out_valid is cleared.
- out_data and out_last are held stable while out_valid & !out_ready.
- Simultaneous events:
  - A write that completes bank A and a read that frees bank B in the same cycle are both applied.
  - A write into bank A while bank B drains is legal.
  - The read side never reads a bank that is not full.
- Both banks full: in_ready = 0 until the first bank's last sample is loaded into the output stage. in_ready returns to 1 on the following cycle.
- Reset behaviour:
  - rst forces all counters, wb, rb and full[1:0] to 0, and sets out_valid = 0, out_last = 0, out_data = 0.
  - Memory contents are not cleared.
  - A partial block in progress when rst is asserted is discarded and is never output.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0.
- Latency: the last sample of a block is accepted at edge k. The first output sample of that block is valid after edge k+1.
- Throughput:
  - 1 sample per cycle sustained on both ports when out_ready = 1.
  - No bubbles between consecutive blocks.
  - in_ready stays 1 throughout a continuous stream.
- Memory reads are registered. Memory writes take effect at the accepting edge.

## Configuration
- TP_MODE_SEL_EN defined:
  - The mode port exists.
  - mode is sampled with the first accepted sample of each block and stored per bank.
  - A bank written with mode = 0 is read with the same addressing as the write (row fastest), so the block passes through in arrival order.
  - A bank written with mode = 1 is transposed.
- TP_MODE_SEL_EN undefined: no mode port; every block is transposed.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1. Required: in_ready = 1, out_valid = 0, out_data = 0 after reset, and no sample accepted while rst is high.
- Single block, N = 8: drive values 0..63 back-to-back with out_ready = 1. Required:
  - out_valid rises 1 cycle after sample 63 is accepted.
  - Output sequence is 0, 8, 16, …, 56, 1, 9, …, 63.
  - out_last is high only on value 63.
- Backpressure: hold out_ready = 0 and stream 0..191. Required:
  - in_ready drops after 128 accepts.
  - out_data stays 0 with out_valid = 1.
  - After out_ready = 1, 128 outputs drain in transposed order and in_ready returns.
- Streaming: 4 consecutive blocks (256 samples) with out_ready = 1. Required: in_ready is never 0, out_valid is continuous after the first output, and there are 4 out_last pulses 64 cycles apart.
- Mid-block reset: pulse rst after 30 samples, then send a full block 100..163. Required: the output is the transpose of 100..163 only, starting with 100, 108.
- With TP_MODE_SEL_EN: block 0..63 with mode = 0, then block 64..127 with mode = 1. Required: the first block outputs 0..63 in order, and the second block outputs 64, 72, ….
